key_event_decoder: RTL and testbench
====================================

// Module: key_event_decoder
// PURPOSE
//  Consumer-side decoder for the debounced, active-low key level (1 = released,
//  0 = pressed). It turns that level into one-cycle event pulses: short press,
//  double click, long press, and auto-repeat while the key is held.
//  It sits between the key debouncer and the application control logic.
// PARAMETERS
//  CNT_W        26          width of the shared interval counter
//  LONG_TIME    50_000_000  hold cycles before long_press fires (1 s at 50 MHz)
//  DCLICK_GAP   15_000_000  max released cycles between the two clicks of a double click
//  REPEAT_TIME  10_000_000  cycles between repeat_pulse events in long hold
//  DCLICK_EN    1           1: double-click detection on; 0: short_press fires on release
// PORTS
//  clk           in   1  system clock
//  rst           in   1  reset; one clock; reset is synchronous and active-high
//  key_vld       in   1  debounced key level, active low
//  short_press   out  1  one-cycle pulse: single click completed
//  double_click  out  1  one-cycle pulse: second click released
//  long_press    out  1  one-cycle pulse: hold reached LONG_TIME
//  repeat_pulse  out  1  one-cycle pulse every REPEAT_TIME during long hold
//  key_held      out  1  level: FSM is in PRESS1, LONG_HOLD or PRESS2
// BEHAVIOUR
//  - key_d: a register holding the previous key_vld sample.
//    press_edge = key_d & ~key_vld; release_edge = ~key_d & key_vld.
//    Reset forces key_d to 0, so a key held through reset is ignored until it is released.
//  - Reset: state=IDLE, cnt=0, key_d=0, all outputs 0. Reset mid-operation drops
//    any pending event and emits no pulse.
//  - All outputs are registered. Each pulse is high exactly one cycle, in the cycle
//    after the deciding edge or timeout. key_held follows the next state
//    (registered), so no pulse is ever wider than one cycle.
//  - cnt clears on every state change. It increments by 1 only in PRESS1, LONG_HOLD
//    and WAIT_2ND and never wraps. Every *_TIME parameter must be < 2**CNT_W and >= 2.
//  - FSM (one-hot, 5 states):
//    IDLE: press_edge -> PRESS1. Release-only activity is ignored.
//    PRESS1: release_edge -> WAIT_2ND (DCLICK_EN=1), or -> IDLE with short_press
//      (DCLICK_EN=0). cnt==LONG_TIME-1 while pressed -> LONG_HOLD, long_press.
//      If both occur in the same cycle, the release wins (short path, no long_press).
//    LONG_HOLD: cnt==REPEAT_TIME-1 -> repeat_pulse and cnt=0 (stay).
//      release_edge -> IDLE with no further pulse. If repeat timeout and release
//      coincide, the release wins and no repeat_pulse is sent.
//    WAIT_2ND: press_edge -> PRESS2. cnt==DCLICK_GAP-1 -> IDLE, short_press.
//      If both occur in the same cycle, the press wins (no short_press).
//    PRESS2: release_edge -> IDLE, double_click. No long/repeat timing in this state.
//    Illegal or unused encoding -> IDLE, outputs 0.
//  - At most one event pulse is high in any cycle.
// STRUCTURE
//  - Shared include key_event_defs.vh: one-hot state localparams
//    (IDLE, PRESS1, LONG_HOLD, WAIT_2ND, PRESS2) and the default timing constants.
//  - Single module, no sub-module. Edge detection, counter and 3-block FSM are inline.
//    Expected size is about 150 lines.
// TESTING  (override LONG_TIME=20, DCLICK_GAP=8, REPEAT_TIME=5, CNT_W=8)
//  1. Press 5 cycles, release, idle 20 cycles -> single short_press 8 cycles after
//     release+1; no other pulse.
//  2. Press 3, release 4, press 3, release -> single double_click the cycle after
//     the 2nd release; no short_press.
//  3. Hold 40 cycles -> long_press at press+21; repeat_pulse at +26, +31, +36;
//     key_held high throughout; release -> no pulse.
//  4. Press held 19 cycles, released on cycle 20 -> release wins: no long_press;
//     short_press follows the gap timeout.
//  5. Key held low across rst deassert -> no event; release then press 5 -> normal
//     short_press.
//  6. DCLICK_EN=0: press 5, release -> short_press the cycle after release.
//     Assert rst in WAIT_2ND -> all outputs 0 next cycle, no pulse ever.

Source files
------------

// File: rtl/key_event_decoder_pkg.sv
// ============================================================================
// Module : key_event_decoder_pkg
// Brief  : State encoding, default timing constants and state-class helpers
//          shared by the key event decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_event_decoder_pkg;

    // One-hot state encoding; any other pattern is treated as illegal.
    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_PRESS1    = 5'b00010,
        ST_LONG_HOLD = 5'b00100,
        ST_WAIT_2ND  = 5'b01000,
        ST_PRESS2    = 5'b10000
    } state_e;

    // Default timing (50 MHz system clock).
    localparam int DEF_CNT_W       = 26;
    localparam int DEF_LONG_TIME   = 50_000_000;
    localparam int DEF_DCLICK_GAP  = 15_000_000;
    localparam int DEF_REPEAT_TIME = 10_000_000;

    // States in which the key is considered held down.
    function automatic logic is_held(input state_e s);
        return (s == ST_PRESS1) || (s == ST_LONG_HOLD) || (s == ST_PRESS2);
    endfunction

    // States in which the interval counter advances.
    function automatic logic is_timed(input state_e s);
        return (s == ST_PRESS1) || (s == ST_LONG_HOLD) || (s == ST_WAIT_2ND);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_decoder.sv
// ============================================================================
// Module : key_event_decoder
// Brief  : Turns a debounced active-low key level into one-cycle event pulses:
//          short press, double click, long press and auto-repeat.
// Ports  : clk, rst (sync, active-high)
//          key_vld       - debounced key level, 0 = pressed
//          short_press   - pulse, single click completed
//          double_click  - pulse, second click released
//          long_press    - pulse, hold reached LONG_TIME
//          repeat_pulse  - pulse every REPEAT_TIME during long hold
//          key_held      - level, key is down (PRESS1/LONG_HOLD/PRESS2)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LONG_TIME   = DEF_LONG_TIME,
    parameter int DCLICK_GAP  = DEF_DCLICK_GAP,
    parameter int REPEAT_TIME = DEF_REPEAT_TIME,
    parameter bit DCLICK_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_vld,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic key_held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DCLICK_GAP - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_dly_q;        // previous key_vld sample
    logic             short_q, short_d;
    logic             dclick_q, dclick_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic             cnt_clr;

    // Reset clears key_dly_q to 0 (pressed), so a key held through reset
    // produces no press edge until it has been released once.
    logic press_edge, release_edge;
    assign press_edge   =  key_dly_q & ~key_vld;
    assign release_edge = ~key_dly_q &  key_vld;

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        short_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_edge) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                // Release is checked first so it beats a coincident long timeout.
                if (release_edge) begin
                    if (DCLICK_EN) begin
                        state_d = ST_WAIT_2ND;
                    end else begin
                        state_d = ST_IDLE;
                        short_d = 1'b1;
                    end
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG_HOLD;
                    long_d  = 1'b1;
                end
            end
            ST_LONG_HOLD: begin
                if (release_edge) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            ST_WAIT_2ND: begin
                // A second press beats a coincident gap timeout.
                if (press_edge) begin
                    state_d = ST_PRESS2;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (release_edge) begin
                    state_d  = ST_IDLE;
                    dclick_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        held_d = is_held(state_d);

        // Counter restarts on any state change and saturates instead of wrapping.
        if ((state_d != state_q) || cnt_clr) begin
            cnt_d = '0;
        end else if (is_timed(state_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            key_dly_q <= 1'b0;
            short_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_dly_q <= key_vld;
            short_q   <= short_d;
            dclick_q  <= dclick_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign short_press  = short_q;
    assign double_click = dclick_q;
    assign long_press   = long_q;
    assign repeat_pulse = repeat_q;
    assign key_held     = held_q;

endmodule

`default_nettype wire

// File: tb/tb_key_event_decoder.sv
// ============================================================================
// Module : tb_key_event_decoder
// Brief  : Directed self-checking bench for key_event_decoder with short
//          timing (LONG=20, GAP=8, REPEAT=5, CNT_W=8); a second instance
//          runs with double-click detection disabled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_event_decoder;

    logic clk;
    logic rst;
    logic key_vld;

    logic sp0, dc0, lp0, rp0, kh0;
    logic sp1, dc1, lp1, rp1, kh1;

    int checks = 0;
    int errors = 0;

    key_event_decoder #(
        .CNT_W(8), .LONG_TIME(20), .DCLICK_GAP(8), .REPEAT_TIME(5), .DCLICK_EN(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .key_vld(key_vld),
        .short_press(sp0), .double_click(dc0), .long_press(lp0),
        .repeat_pulse(rp0), .key_held(kh0)
    );

    key_event_decoder #(
        .CNT_W(8), .LONG_TIME(20), .DCLICK_GAP(8), .REPEAT_TIME(5), .DCLICK_EN(1'b0)
    ) u_dut_nodc (
        .clk(clk), .rst(rst), .key_vld(key_vld),
        .short_press(sp1), .double_click(dc1), .long_press(lp1),
        .repeat_pulse(rp1), .key_held(kh1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse log: count and index of the clock edge that produced the last pulse.
    int edge_n = 0;
    int sp_cnt = 0, dc_cnt = 0, lp_cnt = 0, rp_cnt = 0, multi_cnt = 0;
    int sp_last = -1, dc_last = -1, lp_last = -1, rp_last = -1;
    int sp1_cnt = 0, sp1_last = -1, oth1_cnt = 0;

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        if (sp0) begin sp_cnt++; sp_last = edge_n; end
        if (dc0) begin dc_cnt++; dc_last = edge_n; end
        if (lp0) begin lp_cnt++; lp_last = edge_n; end
        if (rp0) begin rp_cnt++; rp_last = edge_n; end
        if ((int'(sp0) + int'(dc0) + int'(lp0) + int'(rp0)) > 1) multi_cnt++;
        if (sp1) begin sp1_cnt++; sp1_last = edge_n; end
        if (dc1 || lp1 || rp1) oth1_cnt++;
    end

    // Drive key level for n clock edges; returns #1 after the last edge.
    task automatic drive(input logic v, input int n);
        key_vld = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sp0, dc0, lp0, rp0, kh0} !== 5'b0)
            begin errors++; $display("FAIL reset_outputs_dut0 got=%b exp=00000", {sp0, dc0, lp0, rp0, kh0}); end
        checks++;
        if ({sp1, dc1, lp1, rp1, kh1} !== 5'b0)
            begin errors++; $display("FAIL reset_outputs_dut1 got=%b exp=00000", {sp1, dc1, lp1, rp1, kh1}); end
        rst = 1'b0;
        drive(1'b1, 3);
    endtask

    task automatic test_short_press();
        int r, sp_b, oth_b;
        sp_b  = sp_cnt;
        oth_b = dc_cnt + lp_cnt + rp_cnt;
        drive(1'b0, 5);
        checks++;
        if (kh0 !== 1'b1) begin errors++; $display("FAIL short_key_held got=%b exp=1", kh0); end
        r = edge_n;
        drive(1'b1, 20);
        checks++;
        if (sp_cnt - sp_b !== 1) begin errors++; $display("FAIL short_count got=%0d exp=1", sp_cnt - sp_b); end
        checks++;
        if (sp_last !== r + 9) begin errors++; $display("FAIL short_timing got=%0d exp=%0d", sp_last, r + 9); end
        checks++;
        if (dc_cnt + lp_cnt + rp_cnt - oth_b !== 0)
            begin errors++; $display("FAIL short_other_pulses got=%0d exp=0", dc_cnt + lp_cnt + rp_cnt - oth_b); end
    endtask

    task automatic test_double_click();
        int r, sp_b, dc_b;
        sp_b = sp_cnt;
        dc_b = dc_cnt;
        drive(1'b0, 3);
        drive(1'b1, 4);
        drive(1'b0, 3);
        r = edge_n;
        drive(1'b1, 15);
        checks++;
        if (dc_cnt - dc_b !== 1) begin errors++; $display("FAIL dclick_count got=%0d exp=1", dc_cnt - dc_b); end
        checks++;
        if (dc_last !== r + 1) begin errors++; $display("FAIL dclick_timing got=%0d exp=%0d", dc_last, r + 1); end
        checks++;
        if (sp_cnt - sp_b !== 0) begin errors++; $display("FAIL dclick_no_short got=%0d exp=0", sp_cnt - sp_b); end
    endtask

    task automatic test_long_hold();
        int s, lp_b, rp_b, oth_b;
        lp_b  = lp_cnt;
        rp_b  = rp_cnt;
        oth_b = sp_cnt + dc_cnt;
        s = edge_n;
        drive(1'b0, 30);
        checks++;
        if (lp_last !== s + 21) begin errors++; $display("FAIL long_timing got=%0d exp=%0d", lp_last, s + 21); end
        checks++;
        if (rp_last !== s + 26) begin errors++; $display("FAIL repeat_first got=%0d exp=%0d", rp_last, s + 26); end
        checks++;
        if (kh0 !== 1'b1) begin errors++; $display("FAIL long_key_held got=%b exp=1", kh0); end
        drive(1'b0, 10);
        // Release is sampled on edge s+41, coinciding with the fourth repeat timeout.
        drive(1'b1, 10);
        checks++;
        if (lp_cnt - lp_b !== 1) begin errors++; $display("FAIL long_count got=%0d exp=1", lp_cnt - lp_b); end
        checks++;
        if (rp_cnt - rp_b !== 3) begin errors++; $display("FAIL repeat_count got=%0d exp=3", rp_cnt - rp_b); end
        checks++;
        if (rp_last !== s + 36) begin errors++; $display("FAIL repeat_last got=%0d exp=%0d", rp_last, s + 36); end
        checks++;
        if (sp_cnt + dc_cnt - oth_b !== 0)
            begin errors++; $display("FAIL long_release_pulse got=%0d exp=0", sp_cnt + dc_cnt - oth_b); end
        checks++;
        if (kh0 !== 1'b0) begin errors++; $display("FAIL long_released_held got=%b exp=0", kh0); end
    endtask

    task automatic test_long_vs_release();
        int s, lp_b, sp_b;
        lp_b = lp_cnt;
        sp_b = sp_cnt;
        s = edge_n;
        // Release sampled on edge s+21, same edge as the long timeout.
        drive(1'b0, 20);
        drive(1'b1, 15);
        checks++;
        if (lp_cnt - lp_b !== 0) begin errors++; $display("FAIL race_no_long got=%0d exp=0", lp_cnt - lp_b); end
        checks++;
        if (sp_cnt - sp_b !== 1) begin errors++; $display("FAIL race_short_count got=%0d exp=1", sp_cnt - sp_b); end
        checks++;
        if (sp_last !== s + 29) begin errors++; $display("FAIL race_short_timing got=%0d exp=%0d", sp_last, s + 29); end
    endtask

    task automatic test_held_through_reset();
        int r, tot_b, sp_b;
        key_vld = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tot_b = sp_cnt + dc_cnt + lp_cnt + rp_cnt;
        drive(1'b0, 25);
        checks++;
        if (sp_cnt + dc_cnt + lp_cnt + rp_cnt - tot_b !== 0)
            begin errors++; $display("FAIL held_rst_events got=%0d exp=0", sp_cnt + dc_cnt + lp_cnt + rp_cnt - tot_b); end
        checks++;
        if (kh0 !== 1'b0) begin errors++; $display("FAIL held_rst_key_held got=%b exp=0", kh0); end
        drive(1'b1, 3);
        sp_b = sp_cnt;
        drive(1'b0, 5);
        r = edge_n;
        drive(1'b1, 15);
        checks++;
        if (sp_cnt - sp_b !== 1) begin errors++; $display("FAIL held_rst_short_count got=%0d exp=1", sp_cnt - sp_b); end
        checks++;
        if (sp_last !== r + 9) begin errors++; $display("FAIL held_rst_short_timing got=%0d exp=%0d", sp_last, r + 9); end
    endtask

    task automatic test_dclick_disabled();
        int r, sp_b, oth_b;
        sp_b  = sp1_cnt;
        oth_b = oth1_cnt;
        drive(1'b0, 5);
        r = edge_n;
        drive(1'b1, 15);
        checks++;
        if (sp1_cnt - sp_b !== 1) begin errors++; $display("FAIL nodc_short_count got=%0d exp=1", sp1_cnt - sp_b); end
        checks++;
        if (sp1_last !== r + 1) begin errors++; $display("FAIL nodc_short_timing got=%0d exp=%0d", sp1_last, r + 1); end
        checks++;
        if (oth1_cnt - oth_b !== 0) begin errors++; $display("FAIL nodc_other_pulses got=%0d exp=0", oth1_cnt - oth_b); end
    endtask

    task automatic test_reset_in_wait();
        int tot_b;
        drive(1'b0, 5);
        drive(1'b1, 2);
        tot_b = sp_cnt + dc_cnt + lp_cnt + rp_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({sp0, dc0, lp0, rp0, kh0} !== 5'b0)
            begin errors++; $display("FAIL wait_rst_outputs got=%b exp=00000", {sp0, dc0, lp0, rp0, kh0}); end
        rst = 1'b0;
        drive(1'b1, 15);
        checks++;
        if (sp_cnt + dc_cnt + lp_cnt + rp_cnt - tot_b !== 0)
            begin errors++; $display("FAIL wait_rst_events got=%0d exp=0", sp_cnt + dc_cnt + lp_cnt + rp_cnt - tot_b); end
    endtask

    task automatic test_exclusive();
        checks++;
        if (multi_cnt !== 0) begin errors++; $display("FAIL pulse_exclusive got=%0d exp=0", multi_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        key_vld = 1'b1;
        test_reset();
        test_short_press();
        test_double_click();
        test_long_hold();
        test_long_vs_release();
        test_held_through_reset();
        test_dclick_disabled();
        test_reset_in_wait();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
